// File: rtl/btn_pkg.sv
// Shared types for the push-button input path.
package btn_pkg;
    typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} btn_state_t;
    localparam int BTN_COUNT_W = 8;
endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous pad inputs.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/button_reader.sv
// Push-button front end: synchronise, debounce, edge-detect and count presses.
// Optional hold detection (long_pulse) is built when BUTTON_LONG_PRESS_EN is defined.
//
// state       | meaning
// RELEASED    | stable released, waiting for activity
// PRESS_CHK   | activity seen, counting stable pressed cycles
// PRESSED     | stable pressed, waiting for release activity
// RELEASE_CHK | release activity seen, counting stable released cycles
module button_reader
    import btn_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_raw,
    output logic                   level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic                   long_pulse,
    output logic [BTN_COUNT_W-1:0] press_count
);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    logic             act;
    btn_state_t       state, next_state, prev_state;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_det, rel_det;

    sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    assign act = btn_sync ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RELEASED;
            prev_state <= RELEASED;
            cnt        <= '0;
        end else begin
            state      <= next_state;
            prev_state <= state;
            cnt        <= cnt_nxt;
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            RELEASED: begin
                if (act) begin
                    next_state = PRESS_CHK;
                    cnt_nxt    = '0;
                end
            end
            PRESS_CHK: begin
                if (!act) begin
                    next_state = RELEASED;
                    cnt_nxt    = '0;
                end else if (cnt == DB_LAST) begin
                    next_state = PRESSED;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!act) begin
                    next_state = RELEASE_CHK;
                    cnt_nxt    = '0;
                end
            end
            RELEASE_CHK: begin
                if (act) begin
                    next_state = PRESSED;
                    cnt_nxt    = '0;
                end else if (cnt == DB_LAST) begin
                    next_state = RELEASED;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = RELEASED;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Transitions are detected from the registered state pair, adding the one detect stage.
    assign press_det = (prev_state == PRESS_CHK)   && (state == PRESSED);
    assign rel_det   = (prev_state == RELEASE_CHK) && (state == RELEASED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            level         <= (next_state == PRESSED) || (next_state == RELEASE_CHK);
            press_pulse   <= press_det;
            release_pulse <= rel_det;
            if (press_det)
                press_count <= press_count + BTN_COUNT_W'(1);
        end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] hold;
    logic             hold_run;

    // Bounces through RELEASE_CHK keep counting, so one press yields at most one long_pulse.
    assign hold_run = ((state == PRESSED) || (state == RELEASE_CHK)) && (hold != LONG_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_det) begin
                hold <= '0;
            end else if (hold_run) begin
                hold       <= hold + CNT_W'(1);
                long_pulse <= (hold == LONG_MAX - CNT_W'(1));
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader (ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
module tb_button_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic       level, press_pulse, release_pulse, long_pulse;
    logic [7:0] press_count;

    int n_pass = 0;
    int n_total = 0;
    int pp_seen, rp_seen, lp_seen, both_seen, cyc, press_cyc, long_cyc;

    typedef struct {
        logic       raw;
        logic       lvl;
        logic       pp;
        logic       rp;
        logic [7:0] cnt;
    } vec_t;
    vec_t vecs[$];

    button_reader #(
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_total++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act_v, exp_v, $time);
    endtask

    task automatic add(input logic r, input logic l, input logic p, input logic q,
                       input logic [7:0] c, input int n);
        vec_t v;
        v.raw = r; v.lvl = l; v.pp = p; v.rp = q; v.cnt = c;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive raw, let one rising edge sample it, then observe outputs 1 time unit later.
    task automatic step(input logic r);
        btn_raw = r;
        @(posedge clk);
        #1;
        cyc++;
        if (press_pulse) begin pp_seen++; press_cyc = cyc; end
        if (release_pulse) rp_seen++;
        if (long_pulse) begin lp_seen++; long_cyc = cyc; end
        if (press_pulse && release_pulse) both_seen++;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pp_seen = 0; rp_seen = 0; lp_seen = 0; both_seen = 0; cyc = 0;
        press_cyc = -1; long_cyc = -1;
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        #1;
        chk("reset_level", level, 0);
        chk("reset_press_pulse", press_pulse, 0);
        chk("reset_release_pulse", release_pulse, 0);
        chk("reset_long_pulse", long_pulse, 0);
        chk("reset_count", press_count, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held_level", level, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1);
        chk("idle_level", level, 0);
        chk("idle_pulses", {press_pulse, release_pulse, long_pulse}, 0);
        chk("idle_count", press_count, 0);

        // bounce from released: low 3, high 2, low 2, then high
        add(0, 0, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 8);
        // clean press: level at edge 6, pulse and count at edge 7
        add(0, 0, 0, 0, 0, 6);
        add(0, 1, 0, 0, 0, 1);
        add(0, 1, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 4);
        // 2-cycle release glitch while pressed
        add(1, 1, 0, 0, 1, 2);
        add(0, 1, 0, 0, 1, 8);
        // clean release
        add(1, 1, 0, 0, 1, 6);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 1, 1);
        add(1, 0, 0, 0, 1, 4);

        foreach (vecs[i]) begin
            step(vecs[i].raw);
            chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
            chk($sformatf("vec%0d_press", i), press_pulse, vecs[i].pp);
            chk($sformatf("vec%0d_release", i), release_pulse, vecs[i].rp);
            chk($sformatf("vec%0d_count", i), press_count, vecs[i].cnt);
        end

        // wrap: 256 clean presses
        do_reset();
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 10; i++) step(1'b0);
            for (int i = 0; i < 10; i++) step(1'b1);
            if (p == 254) chk("count_255", press_count, 255);
        end
        chk("wrap_count", press_count, 0);
        chk("wrap_press_pulses", pp_seen, 256);
        chk("wrap_release_pulses", rp_seen, 256);
        chk("wrap_both_high", both_seen, 0);
        chk("wrap_no_long", lp_seen, 0);

        // long hold of 40 cycles
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b0);
        for (int i = 0; i < 12; i++) step(1'b1);
        chk("long_press_pulses", pp_seen, 1);
        chk("long_press_at", press_cyc, 8);
`ifdef BUTTON_LONG_PRESS_EN
        chk("long_pulse_count", lp_seen, 1);
        chk("long_pulse_delay", long_cyc - press_cyc, 16);
`else
        chk("long_pulse_count", lp_seen, 0);
`endif

        // reset mid-press, button still held afterwards
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("midrst_pre_level", level, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_level", level, 0);
        chk("midrst_count", press_count, 0);
        chk("midrst_pulses", {press_pulse, release_pulse, long_pulse}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step(1'b0);
            chk($sformatf("midrst_e%0d_press", e), press_pulse, (e == 7) ? 1 : 0);
            chk($sformatf("midrst_e%0d_level", e), level, (e >= 6) ? 1 : 0);
        end
        chk("midrst_final_count", press_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
